// File: rtl/bht_local_hist_pkg.sv
// Shared predictor package: geometry, entry/prediction types and index helpers
// for the local-history branch history table.
package bht_local_hist_pkg;

  localparam int unsigned NR_ENTRIES      = 32;
  localparam int unsigned HIST_LEN        = 3;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned VLEN            = 32;

  localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  localparam int unsigned NR_CTR   = 2 ** HIST_LEN;

  // Weakly not-taken
  localparam logic [1:0] BHT_CTR_INIT = 2'b01;

  typedef enum logic {
    BHT_IDLE  = 1'b0,
    BHT_FLUSH = 1'b1
  } bht_state_e;

  typedef struct packed {
    logic                    valid;
    logic [HIST_LEN-1:0]     hist;
    logic [NR_CTR-1:0][1:0]  ctr;
  } bht_entry_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_pred_t;

  localparam bht_entry_t BHT_ENTRY_INIT = '{
    valid: 1'b0,
    hist:  '0,
    ctr:   {NR_CTR{BHT_CTR_INIT}}
  };

  // Row index = pc[ROW_BITS+1:2]
  function automatic logic [ROW_BITS-1:0] bht_row(input logic [VLEN-1:0] pc);
    return ROW_BITS'(pc >> 2);
  endfunction

  // Column (16-bit slot) = pc[1]
  function automatic logic bht_col(input logic [VLEN-1:0] pc);
    return 1'(pc >> 1);
  endfunction

  // Shift the outcome into the LSB of the local history
  function automatic logic [HIST_LEN-1:0] bht_hist_shift(input logic [HIST_LEN-1:0] hist,
                                                         input logic taken);
    return HIST_LEN'({hist, taken});
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// 2-bit saturating counter next-state logic.
// Ports: i_ctr current value, i_taken direction, i_en apply step, o_ctr next value.
module bht_sat_counter (
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  input  logic       i_en,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_en) begin
      if (i_taken && (i_ctr != 2'd3)) begin
        o_ctr = i_ctr + 2'd1;
      end else if (!i_taken && (i_ctr != 2'd0)) begin
        o_ctr = i_ctr - 2'd1;
      end
    end
  end

endmodule

// File: rtl/bht_local_hist.sv
// Two-level local-history BHT: per-slot prediction for a 32-bit fetch block,
// training from resolved branches, and a row-by-row clear sweep on flush.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_bp_i starts sweep;
// debug_mode_i blocks training; vpc_i fetch address; bht_update_* training port;
// bht_pred_valid_o/bht_pred_taken_o per-slot prediction; bp_ready_o idle flag.
module bht_local_hist
  import bht_local_hist_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       bht_update_valid_i,
  input  logic [VLEN-1:0]            bht_update_pc_i,
  input  logic                       bht_update_taken_i,
  output logic [INSTR_PER_FETCH-1:0] bht_pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_pred_taken_o,
  output logic                       bp_ready_o
);

  bht_state_e          r_state;
  logic [ROW_BITS-1:0] r_ptr;
  logic                r_bp_ready;
  bht_entry_t          r_bht [NR_ROWS][INSTR_PER_FETCH];

  logic                w_idle;
  logic [ROW_BITS-1:0] w_vpc_row;
  logic [ROW_BITS-1:0] w_upd_row;
  logic                w_upd_col;
  logic                w_upd_en;
  bht_entry_t          w_upd_old;
  bht_entry_t          w_upd_new;
  logic [1:0]          w_ctr_next;
  logic [ROW_BITS-1:0] w_clr_row;
  bht_pred_t           w_pred [INSTR_PER_FETCH];

  assign w_idle     = (r_state == BHT_IDLE);
  assign bp_ready_o = r_bp_ready;

  // Zero-latency read of the fetch row; masked while sweeping
  assign w_vpc_row = bht_row(vpc_i);
  for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_pred
    bht_entry_t w_rd;
    assign w_rd             = r_bht[w_vpc_row][g];
    assign w_pred[g].valid  = w_rd.valid & w_idle;
    assign w_pred[g].taken  = w_rd.ctr[w_rd.hist][1] & w_idle;
    assign bht_pred_valid_o[g] = w_pred[g].valid;
    assign bht_pred_taken_o[g] = w_pred[g].taken;
  end

  // Training is dropped while sweeping and when a flush arrives the same cycle
  assign w_upd_row = bht_row(bht_update_pc_i);
  assign w_upd_col = bht_col(bht_update_pc_i);
  assign w_upd_en  = bht_update_valid_i & ~debug_mode_i & w_idle & ~flush_bp_i;
  assign w_upd_old = r_bht[w_upd_row][w_upd_col];

  bht_sat_counter u_sat_counter (
    .i_ctr   (w_upd_old.ctr[w_upd_old.hist]),
    .i_taken (bht_update_taken_i),
    .i_en    (w_upd_en),
    .o_ctr   (w_ctr_next)
  );

  // Only the counter selected by the old history moves
  always_comb begin
    w_upd_new                     = w_upd_old;
    w_upd_new.valid               = 1'b1;
    w_upd_new.ctr[w_upd_old.hist] = w_ctr_next;
    w_upd_new.hist                = bht_hist_shift(w_upd_old.hist, bht_update_taken_i);
  end

  // A flush during the sweep restarts it by clearing row 0 this cycle
  assign w_clr_row = flush_bp_i ? '0 : r_ptr;

  // FSM, sweep pointer and table storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= BHT_IDLE;
      r_ptr      <= '0;
      r_bp_ready <= 1'b1;
      for (int r = 0; r < NR_ROWS; r++) begin
        for (int c = 0; c < INSTR_PER_FETCH; c++) begin
          r_bht[r][c] <= BHT_ENTRY_INIT;
        end
      end
    end else begin
      case (r_state)
        BHT_IDLE: begin
          if (flush_bp_i) begin
            r_state    <= BHT_FLUSH;
            r_ptr      <= '0;
            r_bp_ready <= 1'b0;
          end else if (w_upd_en) begin
            r_bht[w_upd_row][w_upd_col] <= w_upd_new;
          end
        end
        BHT_FLUSH: begin
          for (int c = 0; c < INSTR_PER_FETCH; c++) begin
            r_bht[w_clr_row][c] <= BHT_ENTRY_INIT;
          end
          if (flush_bp_i) begin
            r_ptr <= '0;
          end else if (r_ptr == ROW_BITS'(NR_ROWS - 1)) begin
            r_state    <= BHT_IDLE;
            r_ptr      <= '0;
            r_bp_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ROW_BITS'(1);
          end
        end
        default: begin
          r_state    <= BHT_IDLE;
          r_bp_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bht_local_hist.sv
// Scoreboard bench for bht_local_hist: the driver computes each cycle's expected
// prediction from an abstract table model and queues it; the monitor compares on
// the falling edge.
module tb_bht_local_hist;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [31:0] vpc_i = '0;
  logic        bht_update_valid_i = 1'b0;
  logic [31:0] bht_update_pc_i = '0;
  logic        bht_update_taken_i = 1'b0;
  logic [1:0]  bht_pred_valid_o;
  logic [1:0]  bht_pred_taken_o;
  logic        bp_ready_o;

  always #5 clk_i = ~clk_i;

  bht_local_hist dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_bp_i         (flush_bp_i),
    .debug_mode_i       (debug_mode_i),
    .vpc_i              (vpc_i),
    .bht_update_valid_i (bht_update_valid_i),
    .bht_update_pc_i    (bht_update_pc_i),
    .bht_update_taken_i (bht_update_taken_i),
    .bht_pred_valid_o   (bht_pred_valid_o),
    .bht_pred_taken_o   (bht_pred_taken_o),
    .bp_ready_o         (bp_ready_o)
  );

  typedef struct {
    logic [31:0] vpc;
    logic [1:0]  v;
    logic [1:0]  t;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Abstract model: 32 entries addressed by pc[5:1]
  int m_valid [32];
  int m_hist  [32];
  int m_ctr   [32][8];
  int sweep_row;   // -1 when idle, else next row to clear

  task automatic model_reset();
    for (int e = 0; e < 32; e++) begin
      m_valid[e] = 0;
      m_hist[e]  = 0;
      for (int k = 0; k < 8; k++) m_ctr[e][k] = 1;
    end
    sweep_row = -1;
  endtask

  task automatic clear_row(input int row);
    for (int c = 0; c < 2; c++) begin
      m_valid[row*2+c] = 0;
      m_hist[row*2+c]  = 0;
      for (int k = 0; k < 8; k++) m_ctr[row*2+c][k] = 1;
    end
  endtask

  task automatic apply_update(input logic [31:0] pc, input bit tk);
    int e;
    int h;
    e = int'((pc >> 1) & 32'd31);
    h = m_hist[e];
    m_valid[e] = 1;
    if (tk) m_ctr[e][h] = (m_ctr[e][h] == 3) ? 3 : m_ctr[e][h] + 1;
    else    m_ctr[e][h] = (m_ctr[e][h] == 0) ? 0 : m_ctr[e][h] - 1;
    m_hist[e] = ((h * 2) + (tk ? 1 : 0)) % 8;
  endtask

  // One clock cycle of stimulus; expectation is the pre-edge model state
  task automatic step(input logic [31:0] vpc, input bit upd, input logic [31:0] upc,
                      input bit tk, input bit dbg, input bit fl, input bit rst);
    exp_t ex;
    int   e;
    @(posedge clk_i);
    #1;
    vpc_i              = vpc;
    bht_update_valid_i = upd;
    bht_update_pc_i    = upc;
    bht_update_taken_i = tk;
    debug_mode_i       = dbg;
    flush_bp_i         = fl;
    if (rst) begin
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
      model_reset();
    end
    ex.vpc = vpc;
    ex.rdy = (sweep_row < 0);
    for (int i = 0; i < 2; i++) begin
      e = int'((vpc >> 2) & 32'd15) * 2 + i;
      ex.v[i] = ex.rdy && (m_valid[e] != 0);
      ex.t[i] = ex.rdy && (m_ctr[e][m_hist[e]] >= 2);
    end
    q.push_back(ex);
    if (sweep_row < 0) begin
      if (fl) sweep_row = 0;
      else if (upd && !dbg) apply_update(upc, tk);
    end else if (fl) begin
      clear_row(0);
      sweep_row = 0;
    end else begin
      clear_row(sweep_row);
      sweep_row++;
      if (sweep_row == 16) sweep_row = -1;
    end
  endtask

  task automatic idle(input logic [31:0] vpc);
    step(vpc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input bit tk, input bit dbg);
    step(pc, 1'b1, pc, tk, dbg, 1'b0, 1'b0);
  endtask

  // Monitor: compare outputs against the queued expectation
  exp_t mex;
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      mex = q.pop_front();
      n_tests++;
      if (bht_pred_valid_o !== mex.v || bht_pred_taken_o !== mex.t || bp_ready_o !== mex.rdy) begin
        n_fail++;
        $display("FAIL pred vpc=%h valid=%b exp=%b taken=%b exp=%b ready=%b exp=%b",
                 mex.vpc, bht_pred_valid_o, mex.v, bht_pred_taken_o, mex.t, bp_ready_o, mex.rdy);
      end
    end
  end

  localparam logic [31:0] PC_A = 32'h8000_0010;
  localparam logic [31:0] PC_B = 32'h8000_0012;
  localparam logic [31:0] PC_C = 32'h8000_0020;

  initial begin
    logic [31:0] rv;
    logic [31:0] ru;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    idle(PC_A);
    // Three taken: ctr[7] still weakly not-taken
    repeat (3) train(PC_A, 1'b1, 1'b0);
    idle(PC_A);
    train(PC_A, 1'b1, 1'b0);
    idle(PC_A);
    // Saturate, then one not-taken moves history to 110
    repeat (6) train(PC_A, 1'b1, 1'b0);
    train(PC_A, 1'b0, 1'b0);
    idle(PC_A);
    // Slot 1: debug blocks training, then trains
    train(PC_B, 1'b1, 1'b1);
    idle(PC_A);
    train(PC_B, 1'b1, 1'b0);
    idle(PC_A);
    // Flush with an update injected mid-sweep
    step(PC_A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      if (c == 5) train(PC_A, 1'b1, 1'b0);
      else idle(PC_A);
    end
    idle(PC_A);
    idle(PC_C);
    // Re-flush at sweep cycle 10
    train(PC_A, 1'b1, 1'b0);
    step(PC_A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) idle(PC_A);
    step(PC_A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) idle(PC_A);
    // Reset at sweep cycle 3
    step(PC_A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) idle(PC_A);
    step(PC_A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(PC_A);
    // Flush and update in the same idle cycle: update dropped
    step(PC_A, 1'b1, PC_A, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 17; c++) idle(PC_A);
    // Same-cycle read and write: no bypass
    train(PC_C, 1'b1, 1'b0);
    idle(PC_C);

    // Randomized traffic over a few rows plus aliasing upper bits
    for (int n = 0; n < 3000; n++) begin
      rv = 32'h8000_0000 | ($urandom & 32'h3E) | (32'($urandom_range(0, 3)) << 12);
      ru = ($urandom_range(0, 3) == 0) ? rv
         : (32'h8000_0000 | ($urandom & 32'h3E) | (32'($urandom_range(0, 3)) << 12));
      step(rv, ($urandom_range(0, 1) == 1), ru, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 499) == 0));
    end

    repeat (3) @(posedge clk_i);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_local_hist.md
Name: bht_local_hist

Overview:
- Two-level local-history branch history table for the cv32a65x frontend (BPType BHT, 32 entries, 3-bit history).
- Feeds the frontend predecode/redirect logic with one taken/not-taken prediction per 16-bit slot of the 32-bit fetch block.
- Trained by resolved branches from the execute stage.
- Runs a multi-cycle sweep on predictor flush.

Parameters:
- NR_ENTRIES, 32, total predictor entries; power of 2, ≥ INSTR_PER_FETCH.
- HIST_LEN, 3, local history bits per entry; ≥ 1.
- INSTR_PER_FETCH, 2, 16-bit slots per fetch block (RVC enabled).
- VLEN, 32, virtual address width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset.
- flush_bp_i  in  1  start predictor-clear sweep.
- debug_mode_i  in  1  core in debug mode; training suppressed.
- vpc_i  in  VLEN  fetch block address; bits [1:0] ignored.
- bht_update_valid_i  in  1  resolved conditional branch this cycle.
- bht_update_pc_i  in  VLEN  PC of the resolved branch.
- bht_update_taken_i  in  1  branch outcome.
- bht_pred_valid_o  out  INSTR_PER_FETCH  per-slot entry valid.
- bht_pred_taken_o  out  INSTR_PER_FETCH  per-slot taken prediction.
- bp_ready_o  out  1  high when not sweeping.

Interface (already decided): one clock, clk_i; asynchronous, active-low reset, rst_ni.

Behaviour:
- Geometry:
  - NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH (16).
  - ROW_BITS = clog2(NR_ROWS) (4).
  - Row index = pc[ROW_BITS+1:2].
  - Column = pc[1].
- Entry contents:
  - valid (1 bit).
  - hist (HIST_LEN bits).
  - ctr[2**HIST_LEN], each a 2-bit saturating counter.
- Reset (async, rst_ni low):
  - all valid=0, hist=0, ctr=2'b01 (weakly not-taken).
  - FSM=IDLE, sweep ptr=0.
  - Outputs: bht_pred_valid_o=0, bht_pred_taken_o=0, bp_ready_o=1.
- Prediction (combinational from vpc_i, zero latency), for each column i of row(vpc_i):
  - valid_o[i] = entry.valid.
  - taken_o[i] = entry.ctr[entry.hist][1].
  - Both outputs forced to 0 while FSM=FLUSH.
- Update (registered, takes effect at the next rising edge):
  - Applies when bht_update_valid_i && !debug_mode_i && FSM==IDLE, to entry (row(update_pc), update_pc[1]).
  - valid <= 1.
  - ctr[hist] increments (saturate at 3) if taken, else decrements (saturate at 0).
  - hist <= {hist[HIST_LEN-2:0], taken}; for HIST_LEN==1, hist <= taken.
  - Only ctr[old hist] is modified.
- Same-cycle read/write of the same entry: prediction returns pre-update state; new state is visible the following cycle. No bypass.
- FSM:
  - IDLE -> FLUSH on flush_bp_i; ptr <= 0.
  - FLUSH: each cycle clear row ptr (all columns: valid=0, hist=0, ctr=01); ptr++.
  - FLUSH -> IDLE after clearing row NR_ROWS-1. The sweep takes exactly NR_ROWS cycles with bp_ready_o=0.
  - flush_bp_i during FLUSH restarts the sweep: ptr <= 0, and the row cleared that cycle is row 0.
  - Updates arriving during FLUSH are dropped, not queued.
  - flush_bp_i and an update in the same IDLE cycle: flush wins, update dropped.
- Async reset mid-sweep: returns to the reset state immediately; no sweep is needed afterwards.
- ptr width is ROW_BITS. Wrap to 0 on sweep completion is not an error.
- Upper PC bits above the index are not tagged; aliasing is intended.

Decomposition:
- Add to the shared predictor package:
  - typedef bht_entry_t {valid, hist, ctr array}.
  - typedef bht_pred_t {valid, taken}.
  - BHT_CTR_INIT = 2'b01.
  - Row/column index helper functions.
- One sub-module: bht_sat_counter. It is combinational, taking ctr in, taken, and enable, and producing the next ctr with saturation. It is reused by the update path.
- FSM, sweep pointer and storage array stay in bht_local_hist.

Test Plan:
- Reset release, vpc_i=0x8000_0010 -> pred_valid=2'b00, pred_taken=2'b00, bp_ready_o=1.
- Train pc 0x8000_0010 taken x3:
  - Then vpc_i=0x8000_0010 -> valid[0]=1, taken[0]=0 (ctr[111]=01).
  - 4th taken update -> taken[0]=1.
  - Slot 1 still valid=0.
- After the above, 6 more taken updates then 1 not-taken -> ctr[111]=10, hist=110, ctr[110]=01 -> taken[0]=0 next cycle.
- Training through the pc[1] path and a combined flush:
  - Update pc 0x8000_0012 taken while debug_mode_i=1 -> no change (valid[1]=0).
  - Repeat with debug_mode_i=0 -> valid[1]=1.
  - Pulse flush_bp_i -> bp_ready_o=0 for exactly 16 cycles, predictions 0.
  - An update injected at cycle 5 of the sweep is dropped.
  - After the sweep, all valid=0.
- Flush re-asserted at sweep cycle 10 -> bp_ready_o stays low 16 further cycles. rst_ni pulsed at sweep cycle 3 -> bp_ready_o=1 immediately after reset.
- Same cycle: update pc 0x8000_0020 and vpc_i=0x8000_0020 -> old prediction (valid=0) that cycle; valid=1 next cycle.
